// File: rtl/rope_collision_manager.sv
`default_nettype none
// ============================================================================
//  Module   : rope_collision_manager
//  Purpose  : Per-frame collision collector for the rope display stage.
//             It accumulates rope/border and rope/monkey overlaps over a
//             frame. At each startOfFrame it issues one-cycle dirToggle
//             pulses and frame-held monkeyCollision levels. A per-rope
//             cooldown stops repeated toggles while a rope is still in a wall.
//  Revision : 1.0 - initial release
// ============================================================================
module rope_collision_manager #(
  parameter int ROPES           = 6,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic [ROPES-1:0] ropeDR,
  input  logic             borderDR,
  input  logic             monkeyDR,
  output logic [ROPES-1:0] dirToggle,
  output logic [ROPES-1:0] monkeyCollision,
  output logic             anyMonkeyHit
);

  localparam logic [0:0]       ST_READY    = 1'b0;
  localparam logic [0:0]       ST_COOLDOWN = 1'b1;
  localparam logic [CNT_W-1:0] C_COOL_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  // Overlap terms for the current pixel
  logic [ROPES-1:0] w_borderTerm;
  logic [ROPES-1:0] w_monkeyTerm;
  assign w_borderTerm = ropeDR & {ROPES{borderDR}};
  assign w_monkeyTerm = ropeDR & {ROPES{monkeyDR}};

  logic [ROPES-1:0] borderHit_q;
  logic [ROPES-1:0] monkeyHit_q;
  logic [ROPES-1:0] w_toggle;

  logic [ROPES-1:0] dirToggle_q;
  logic [ROPES-1:0] monkeyCollision_q;
  logic             anyMonkeyHit_q;

  // Hit latches: accumulate within a frame; the frame-boundary pixel starts the new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      borderHit_q <= '0;
      monkeyHit_q <= '0;
    end else if (startOfFrame) begin
      borderHit_q <= w_borderTerm;
      monkeyHit_q <= w_monkeyTerm;
    end else begin
      borderHit_q <= borderHit_q | w_borderTerm;
      monkeyHit_q <= monkeyHit_q | w_monkeyTerm;
    end
  end

  // Per-rope toggle/cooldown state machines
  generate
    for (genvar g = 0; g < ROPES; g++) begin : g_rope
      logic [0:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             toggle_d;

      // Next-state decision, evaluated only at frame boundaries
      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        toggle_d = 1'b0;
        if (startOfFrame) begin
          if (state_q == ST_READY) begin
            if (borderHit_q[g]) begin
              toggle_d = 1'b1;
              if (COOLDOWN_FRAMES != 0) begin
                state_d = ST_COOLDOWN;
                cnt_d   = C_COOL_LOAD;
              end
            end
          end else begin
            // Border hits are ignored; counting down to 0 releases the rope,
            // and the counter never wraps below 0
            if (cnt_q <= C_CNT_ONE) begin
              cnt_d   = '0;
              state_d = ST_READY;
            end else begin
              cnt_d = cnt_q - C_CNT_ONE;
            end
          end
        end
      end

      // State and counter registers
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= ST_READY;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign w_toggle[g] = toggle_d;
    end
  endgenerate

  // Registered outputs: toggles last one cycle, monkey levels hold for a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      dirToggle_q       <= '0;
      monkeyCollision_q <= '0;
      anyMonkeyHit_q    <= 1'b0;
    end else begin
      dirToggle_q <= w_toggle;
      if (startOfFrame) begin
        monkeyCollision_q <= monkeyHit_q;
        anyMonkeyHit_q    <= |monkeyHit_q;
      end
    end
  end

  assign dirToggle       = dirToggle_q;
  assign monkeyCollision = monkeyCollision_q;
  assign anyMonkeyHit    = anyMonkeyHit_q;

endmodule
`default_nettype wire
